// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO complete in a single cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 is_div_q, neg_res_q, neg_rem_q, divz_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 sa, sb;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_rem_sh, div_diff;
  logic [WIDTH-1:0]     q_raw, r_raw, q_fix, r_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  always_comb begin
    sa    = ~op[0] & A[WIDTH-1];
    sb    = ~op[0] & B[WIDTH-1];
    abs_a = sa ? -A : A;
    abs_b = sb ? -B : B;

    // acc_q holds {product_hi, multiplier/product_lo} or {remainder, dividend/quotient}
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, b_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    q_raw = acc_q[WIDTH-1:0];
    r_raw = acc_q[2*WIDTH-1:WIDTH];
    // Zero divisor: the restoring loop already yields all-ones and |A|; skip the negation.
    q_fix    = divz_q ? '1 : (neg_res_q ? -q_raw : q_raw);
    r_fix    = neg_rem_q ? -r_raw : r_raw;
    prod_fix = neg_res_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                a_q       <= abs_a;
                b_q       <= abs_b;
                acc_q     <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                is_div_q  <= op[1];
                neg_res_q <= sa ^ sb;
                neg_rem_q <= sa;
                divz_q    <= op[1] & (B == '0);
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                state_q   <= S_CALC;
              end
              3'b100: begin
                hi_q   <= A;
                done_q <= 1'b1;
              end
              3'b101: begin
                lo_q   <= A;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
